// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states, control bundle, bubble encoding.
// Optional perf counters in the controller are enabled by PIPE_HAZARD_CTRL_PERF_EN.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // Stage control word that a flushed pipeline register loads as a bubble
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } stage_ctl_t;

    localparam stage_ctl_t BUBBLE_CTL = '{
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0
    };

    // Enable / flush controls for every pipeline register in one word
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_RUN = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b0
    };

    localparam pipe_ctl_t CTL_LOAD_USE = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b1, memwb_flush: 1'b0
    };

    localparam pipe_ctl_t CTL_BRANCH = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1, memwb_flush: 1'b0
    };

    localparam pipe_ctl_t CTL_FREEZE = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b1
    };

    localparam pipe_ctl_t CTL_HALT = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b1, idex_flush: 1'b1, memwb_flush: 1'b1
    };

    // Controls when memory is not blocking: branch squashes the load-use victim
    function automatic pipe_ctl_t run_ctl(input logic branch_taken, input logic load_use);
        if (branch_taken) begin
            return CTL_BRANCH;
        end
        if (load_use) begin
            return CTL_LOAD_USE;
        end
        return CTL_RUN;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, register enables/flushes out.
// Perf counter signals exist only when PIPE_HAZARD_CTRL_PERF_EN is defined.
interface pipe_hazard_ctrl_if
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    #(parameter int unsigned CNT_W = 32)
`endif
    ;
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_ready;

    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
    logic mem_timeout;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
`endif

    // Pipeline side
    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        output ex_rd_addr, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, memwb_flush, mem_timeout
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        input  stall_cycles, flush_events
`endif
    );

    // Controller side
    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        input  ex_rd_addr, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, memwb_flush, mem_timeout
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        output stall_cycles, flush_events
`endif
    );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX writes a register the ID instruction reads.
// Kept standalone so the forwarding unit can reuse it.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_mem_read,
    output logic                  lu_c
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
    assign rs2_hit = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);

    // x0 is never written, so a load to x0 cannot create a dependency
    assign lu_c = ex_mem_read && (ex_rd_addr != REG_ADDR_W'(0)) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: hold/bubble controls for load-use, taken branch and memory waits.
// Define PIPE_HAZARD_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [WAIT_W-1:0] wait_inc;
    logic              lu_c;
    logic              mem_block_c;
    pipe_ctl_t         run_ctl_c;
    pipe_ctl_t         ctl_c;

    load_use_detect u_load_use_detect (
        .id_rs1_addr (bus.id_rs1_addr),
        .id_rs2_addr (bus.id_rs2_addr),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .ex_rd_addr  (bus.ex_rd_addr),
        .ex_mem_read (bus.ex_mem_read),
        .lu_c        (lu_c)
    );

    assign mem_block_c = bus.mem_req && !bus.mem_ready;
    assign run_ctl_c   = run_ctl(bus.ex_branch_taken, lu_c);
    assign wait_inc    = wait_q + WAIT_W'(1);

    // State and wait-counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state and pipeline controls
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ctl_c   = CTL_RUN;
        unique case (state_q)
            RUN: begin
                if (mem_block_c) begin
                    ctl_c   = CTL_FREEZE;
                    wait_d  = WAIT_W'(1);
                    state_d = (MEM_TIMEOUT <= 1) ? HALT : MEM_WAIT;
                end else begin
                    ctl_c = run_ctl_c;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    ctl_c   = run_ctl_c;
                    wait_d  = '0;
                    state_d = RUN;
                end else begin
                    ctl_c  = CTL_FREEZE;
                    wait_d = wait_inc;
                    // wait_inc counts this cycle plus every earlier unanswered cycle
                    if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                ctl_c = CTL_HALT;
            end
            default: begin
                ctl_c   = CTL_HALT;
                state_d = RUN;
            end
        endcase
        if (!rst_n) begin
            ctl_c = CTL_HALT;
        end
    end

    assign bus.pc_en       = ctl_c.pc_en;
    assign bus.ifid_en     = ctl_c.ifid_en;
    assign bus.idex_en     = ctl_c.idex_en;
    assign bus.exmem_en    = ctl_c.exmem_en;
    assign bus.memwb_en    = ctl_c.memwb_en;
    assign bus.ifid_flush  = ctl_c.ifid_flush;
    assign bus.idex_flush  = ctl_c.idex_flush;
    assign bus.memwb_flush = ctl_c.memwb_flush;
    assign bus.mem_timeout = (state_q == HALT);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             flush_evt_c;

    // Only the branch rule produces the branch control word; reset forces CTL_HALT
    assign flush_evt_c = (ctl_c == CTL_BRANCH);

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!ctl_c.pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_evt_c && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (perf checks when PIPE_HAZARD_CTRL_PERF_EN is defined).
module tb_pipe_hazard_ctrl;

    localparam int unsigned TIMEOUT = 16;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush}
    localparam logic [7:0] EXP_RUN  = 8'b11111_000;
    localparam logic [7:0] EXP_LU   = 8'b00111_010;
    localparam logic [7:0] EXP_BR   = 8'b11111_110;
    localparam logic [7:0] EXP_FRZ  = 8'b00000_001;
    localparam logic [7:0] EXP_HALT = 8'b00000_111;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (TIMEOUT)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .CNT_W       (32)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [7:0] ctl_obs;
    assign ctl_obs = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                      bus.ifid_flush, bus.idex_flush, bus.memwb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.id_rs1_addr     = 5'd0;
        bus.id_rs2_addr     = 5'd0;
        bus.id_uses_rs1     = 1'b0;
        bus.id_uses_rs2     = 1'b0;
        bus.ex_rd_addr      = 5'd0;
        bus.ex_mem_read     = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_req         = 1'b0;
        bus.mem_ready       = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic use1, input logic use2);
        bus.ex_mem_read = 1'b1;
        bus.ex_rd_addr  = rd;
        bus.id_rs1_addr = rs1;
        bus.id_rs2_addr = rs2;
        bus.id_uses_rs1 = use1;
        bus.id_uses_rs2 = use2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_HALT) begin
            n_fail++;
            $display("FAIL reset_forced_ctl: got %b expected %b", ctl_obs, EXP_HALT);
        end
        n_checks++;
        if (bus.mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_timeout: got %b expected 0", bus.mem_timeout);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_RUN) begin
            n_fail++;
            $display("FAIL reset_release_run: got %b expected %b", ctl_obs, EXP_RUN);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        // rs1 match: one bubble, then the load has moved on
        set_lu(5'd5, 5'd5, 5'd7, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_LU) begin
            n_fail++;
            $display("FAIL lu_rs1: got %b expected %b", ctl_obs, EXP_LU);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_RUN) begin
            n_fail++;
            $display("FAIL lu_one_cycle: got %b expected %b", ctl_obs, EXP_RUN);
        end
        next_cycle();
        set_lu(5'd9, 5'd3, 5'd9, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_LU) begin
            n_fail++;
            $display("FAIL lu_rs2: got %b expected %b", ctl_obs, EXP_LU);
        end
        next_cycle();
        set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_RUN) begin
            n_fail++;
            $display("FAIL lu_rd_zero: got %b expected %b", ctl_obs, EXP_RUN);
        end
        next_cycle();
        set_lu(5'd5, 5'd5, 5'd5, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_RUN) begin
            n_fail++;
            $display("FAIL lu_unused_src: got %b expected %b", ctl_obs, EXP_RUN);
        end
        next_cycle();
        set_lu(5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
        bus.ex_mem_read = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_RUN) begin
            n_fail++;
            $display("FAIL lu_not_load: got %b expected %b", ctl_obs, EXP_RUN);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_branch();
        set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        bus.ex_branch_taken = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_BR) begin
            n_fail++;
            $display("FAIL branch_over_lu: got %b expected %b", ctl_obs, EXP_BR);
        end
        next_cycle();
        idle();
        bus.ex_branch_taken = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_BR) begin
            n_fail++;
            $display("FAIL branch_only: got %b expected %b", ctl_obs, EXP_BR);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_mem_wait();
        // Three unanswered cycles freeze, fourth releases
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (ctl_obs !== EXP_FRZ) begin
                n_fail++;
                $display("FAIL mem_freeze_c%0d: got %b expected %b", i, ctl_obs, EXP_FRZ);
            end
            next_cycle();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_RUN) begin
            n_fail++;
            $display("FAIL mem_release: got %b expected %b", ctl_obs, EXP_RUN);
        end
        next_cycle();
        // Back in RUN: no request and no ready must not freeze
        idle();
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_RUN) begin
            n_fail++;
            $display("FAIL mem_back_to_run: got %b expected %b", ctl_obs, EXP_RUN);
        end
        next_cycle();
        // Memory wait outranks a branch; branch re-evaluated on release
        bus.mem_req = 1'b1;
        bus.ex_branch_taken = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_FRZ) begin
            n_fail++;
            $display("FAIL mem_over_branch: got %b expected %b", ctl_obs, EXP_FRZ);
        end
        next_cycle();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_BR) begin
            n_fail++;
            $display("FAIL mem_release_branch: got %b expected %b", ctl_obs, EXP_BR);
        end
        next_cycle();
        // Ready together with request never waits; load-use still applies
        idle();
        bus.mem_req = 1'b1;
        bus.mem_ready = 1'b1;
        set_lu(5'd12, 5'd1, 5'd12, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_LU) begin
            n_fail++;
            $display("FAIL mem_ready_same_cycle: got %b expected %b", ctl_obs, EXP_LU);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_RUN) begin
            n_fail++;
            $display("FAIL mem_no_wait_entered: got %b expected %b", ctl_obs, EXP_RUN);
        end
        next_cycle();
    endtask

    task automatic test_reset_in_wait();
        bus.mem_req = 1'b1;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_HALT) begin
            n_fail++;
            $display("FAIL wait_reset_forced: got %b expected %b", ctl_obs, EXP_HALT);
        end
        next_cycle();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_RUN) begin
            n_fail++;
            $display("FAIL wait_reset_to_run: got %b expected %b", ctl_obs, EXP_RUN);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        bus.mem_req = 1'b1;
        for (int i = 1; i <= int'(TIMEOUT); i++) begin
            @(negedge clk);
            n_checks++;
            if (ctl_obs !== EXP_FRZ || bus.mem_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait_c%0d: got %b/%b expected %b/0",
                         i, ctl_obs, bus.mem_timeout, EXP_FRZ);
            end
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (ctl_obs !== EXP_HALT || bus.mem_timeout !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_halt_c%0d: got %b/%b expected %b/1",
                         i, ctl_obs, bus.mem_timeout, EXP_HALT);
            end
            next_cycle();
            // Memory finally answering must not leave HALT
            bus.mem_ready = 1'b1;
            bus.mem_req = 1'b0;
        end
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        n_checks++;
        if (ctl_obs !== EXP_RUN || bus.mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_reset: got %b/%b expected %b/0", ctl_obs, bus.mem_timeout, EXP_RUN);
        end
        next_cycle();
    endtask

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    task automatic test_perf();
        apply_reset();
        set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        next_cycle();
        idle();
        next_cycle();
        set_lu(5'd6, 5'd0, 5'd6, 1'b0, 1'b1);
        next_cycle();
        idle();
        next_cycle();
        bus.mem_req = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        bus.mem_ready = 1'b1;
        next_cycle();
        idle();
        bus.ex_branch_taken = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (bus.stall_cycles !== 32'd5) begin
            n_fail++;
            $display("FAIL perf_stall_cycles: got %0d expected 5", bus.stall_cycles);
        end
        n_checks++;
        if (bus.flush_events !== 32'd1) begin
            n_fail++;
            $display("FAIL perf_flush_events: got %0d expected 1", bus.flush_events);
        end
        next_cycle();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_reset_in_wait();
        test_timeout();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
